// File: rtl/rf_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package rf_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] word_t;

    function automatic logic is_zero_idx(input int unsigned idx);
        return idx == 0;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register suppression, write bypass
// and busy lookup for a single source operand.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0]   srcReg,
    input  logic [DATA_W-1:0]   regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busyVec,
    input  logic                wrQual,
    input  logic [ADDR_W-1:0]   dstReg,
    input  logic [DATA_W-1:0]   dstData,
    output logic [DATA_W-1:0]   srcData,
    output logic                busy
);

    logic zeroHit;
    logic bypassHit;

    assign zeroHit   = (ZERO_REG != 0) && is_zero_idx(32'(srcReg));
    assign bypassHit = (BYPASS != 0) && wrQual && (dstReg == srcReg);

    // Bypassed operands report not-busy so the consumer can proceed.
    always_comb begin
        srcData = regs[srcReg];
        busy    = busyVec[srcReg];
        if (zeroHit) begin
            srcData = '0;
            busy    = 1'b0;
        end else if (bypassHit) begin
            srcData = dstData;
            busy    = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with optional bypass, hardwired
// zero register and a per-register busy scoreboard.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic              WriteReg,
    input  logic [DATA_W-1:0] DstData,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    output logic              AnyBusy
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                writeQual;
    logic                issueQual;
    logic                dstZero;
    logic                issueZero;

    assign dstZero   = (ZERO_REG != 0) && is_zero_idx(32'(DstReg));
    assign issueZero = (ZERO_REG != 0) && is_zero_idx(32'(IssueReg));

    // Reset also masks the bypass so outputs read clean during reset.
    assign writeQual = WriteReg && !rst && !dstZero;
    assign issueQual = IssueValid && !rst && !issueZero;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (writeQual) begin
                regs[DstReg] <= DstData;
                busy[DstReg] <= 1'b0;
            end
            // A new producer supersedes a same-cycle writeback.
            if (issueQual) begin
                busy[IssueReg] <= 1'b1;
            end
        end
    end

    assign AnyBusy = |busy;

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) uPort1 (
        .srcReg  (SrcReg1),
        .regs    (regs),
        .busyVec (busy),
        .wrQual  (writeQual),
        .dstReg  (DstReg),
        .dstData (DstData),
        .srcData (SrcData1),
        .busy    (Busy1)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) uPort2 (
        .srcReg  (SrcReg2),
        .regs    (regs),
        .busyVec (busy),
        .wrQual  (writeQual),
        .dstReg  (DstReg),
        .dstData (DstData),
        .srcData (SrcData2),
        .busy    (Busy2)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: default instance plus a BYPASS=0/ZERO_REG=0 instance
// driven in lockstep.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  SrcReg1 = '0;
    logic [3:0]  SrcReg2 = '0;
    logic [3:0]  DstReg = '0;
    logic        WriteReg = 1'b0;
    logic [15:0] DstData = '0;
    logic        IssueValid = 1'b0;
    logic [3:0]  IssueReg = '0;

    logic [15:0] SrcData1, SrcData2, aSrcData1, aSrcData2;
    logic        Busy1, Busy2, AnyBusy, aBusy1, aBusy2, aAnyBusy;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       rst;
        logic       wr;
        logic [3:0] dst;
        logic [15:0] data;
        logic       iv;
        logic [3:0] ireg;
        logic [3:0] s1;
        logic [3:0] s2;
    } stim_t;

    typedef struct packed {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        b1;
        logic        b2;
        logic        any;
        logic [15:0] ad1;
        logic [15:0] ad2;
        logic        ab1;
        logic        ab2;
        logic        aany;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .SrcReg1    (SrcReg1),
        .SrcReg2    (SrcReg2),
        .SrcData1   (SrcData1),
        .SrcData2   (SrcData2),
        .Busy1      (Busy1),
        .Busy2      (Busy2),
        .DstReg     (DstReg),
        .WriteReg   (WriteReg),
        .DstData    (DstData),
        .IssueValid (IssueValid),
        .IssueReg   (IssueReg),
        .AnyBusy    (AnyBusy)
    );

    regfile_sb #(
        .BYPASS   (0),
        .ZERO_REG (0)
    ) alt (
        .clk        (clk),
        .rst        (rst),
        .SrcReg1    (SrcReg1),
        .SrcReg2    (SrcReg2),
        .SrcData1   (aSrcData1),
        .SrcData2   (aSrcData2),
        .Busy1      (aBusy1),
        .Busy2      (aBusy2),
        .DstReg     (DstReg),
        .WriteReg   (WriteReg),
        .DstData    (DstData),
        .IssueValid (IssueValid),
        .IssueReg   (IssueReg),
        .AnyBusy    (aAnyBusy)
    );

    function automatic stim_t mkS(int r, int w, int d, int dat,
                                  int iv, int ir, int s1, int s2);
        stim_t s;
        s.rst  = 1'(r);
        s.wr   = 1'(w);
        s.dst  = 4'(d);
        s.data = 16'(dat);
        s.iv   = 1'(iv);
        s.ireg = 4'(ir);
        s.s1   = 4'(s1);
        s.s2   = 4'(s2);
        return s;
    endfunction

    function automatic exp_t mkE(int d1, int d2, int b1, int b2, int an,
                                 int ad1, int ad2, int ab1, int ab2, int aan);
        exp_t e;
        e.d1   = 16'(d1);
        e.d2   = 16'(d2);
        e.b1   = 1'(b1);
        e.b2   = 1'(b2);
        e.any  = 1'(an);
        e.ad1  = 16'(ad1);
        e.ad2  = 16'(ad2);
        e.ab1  = 1'(ab1);
        e.ab2  = 1'(ab2);
        e.aany = 1'(aan);
        return e;
    endfunction

    task automatic drive(input stim_t s);
        rst        = s.rst;
        WriteReg   = s.wr;
        DstReg     = s.dst;
        DstData    = s.data;
        IssueValid = s.iv;
        IssueReg   = s.ireg;
        SrcReg1    = s.s1;
        SrcReg2    = s.s2;
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got;
        logic [69:0] obs;
        s.push_back(mkS(1, 0, 0, 0, 0, 0, 0, 0));
        e.push_back(mkE(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) begin
            s.push_back(mkS(0, 0, 0, 0, 0, 0, i, 15 - i));
            e.push_back(mkE(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i]);
            sbq.push_back(e[i]);
            @(negedge clk);
            got = sbq.pop_front();
            obs = {SrcData1, SrcData2, Busy1, Busy2, AnyBusy,
                   aSrcData1, aSrcData2, aBusy1, aBusy2, aAnyBusy};
            checks++;
            if (obs !== got) begin
                failures++;
                $display("FAIL reset[%0d] got=%h want=%h", i, obs, got);
            end
        end
    endtask

    task automatic test_write_read();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got;
        logic [69:0] obs;
        s.push_back(mkS(0, 1, 5, 'hBEEF, 0, 0, 5, 5));
        e.push_back(mkE('hBEEF, 'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 5, 5));
        e.push_back(mkE('hBEEF, 'hBEEF, 0, 0, 0, 'hBEEF, 'hBEEF, 0, 0, 0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i]);
            sbq.push_back(e[i]);
            @(negedge clk);
            got = sbq.pop_front();
            obs = {SrcData1, SrcData2, Busy1, Busy2, AnyBusy,
                   aSrcData1, aSrcData2, aBusy1, aBusy2, aAnyBusy};
            checks++;
            if (obs !== got) begin
                failures++;
                $display("FAIL write_read[%0d] got=%h want=%h", i, obs, got);
            end
        end
    endtask

    task automatic test_bypass();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got;
        logic [69:0] obs;
        s.push_back(mkS(0, 1, 7, 'h1234, 0, 0, 5, 7));
        e.push_back(mkE('hBEEF, 'h1234, 0, 0, 0, 'hBEEF, 0, 0, 0, 0));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 5, 7));
        e.push_back(mkE('hBEEF, 'h1234, 0, 0, 0, 'hBEEF, 'h1234, 0, 0, 0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i]);
            sbq.push_back(e[i]);
            @(negedge clk);
            got = sbq.pop_front();
            obs = {SrcData1, SrcData2, Busy1, Busy2, AnyBusy,
                   aSrcData1, aSrcData2, aBusy1, aBusy2, aAnyBusy};
            checks++;
            if (obs !== got) begin
                failures++;
                $display("FAIL bypass[%0d] got=%h want=%h", i, obs, got);
            end
        end
    endtask

    task automatic test_zero();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got;
        logic [69:0] obs;
        s.push_back(mkS(0, 1, 0, 'hFFFF, 1, 0, 0, 0));
        e.push_back(mkE(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 0, 0));
        e.push_back(mkE(0, 0, 0, 0, 0, 'hFFFF, 'hFFFF, 1, 1, 1));
        s.push_back(mkS(0, 1, 0, 'hFFFF, 0, 0, 0, 0));
        e.push_back(mkE(0, 0, 0, 0, 0, 'hFFFF, 'hFFFF, 1, 1, 1));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 0, 0));
        e.push_back(mkE(0, 0, 0, 0, 0, 'hFFFF, 'hFFFF, 0, 0, 0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i]);
            sbq.push_back(e[i]);
            @(negedge clk);
            got = sbq.pop_front();
            obs = {SrcData1, SrcData2, Busy1, Busy2, AnyBusy,
                   aSrcData1, aSrcData2, aBusy1, aBusy2, aAnyBusy};
            checks++;
            if (obs !== got) begin
                failures++;
                $display("FAIL zero_reg[%0d] got=%h want=%h", i, obs, got);
            end
        end
    endtask

    task automatic test_scoreboard();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got;
        logic [69:0] obs;
        s.push_back(mkS(0, 0, 0, 0, 1, 3, 3, 0));
        e.push_back(mkE(0, 0, 0, 0, 0, 0, 'hFFFF, 0, 0, 0));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 3, 0));
        e.push_back(mkE(0, 0, 1, 0, 1, 0, 'hFFFF, 1, 0, 1));
        s.push_back(mkS(0, 1, 3, 'h0042, 0, 0, 3, 0));
        e.push_back(mkE('h0042, 0, 0, 0, 1, 0, 'hFFFF, 1, 0, 1));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 3, 0));
        e.push_back(mkE('h0042, 0, 0, 0, 0, 'h0042, 'hFFFF, 0, 0, 0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i]);
            sbq.push_back(e[i]);
            @(negedge clk);
            got = sbq.pop_front();
            obs = {SrcData1, SrcData2, Busy1, Busy2, AnyBusy,
                   aSrcData1, aSrcData2, aBusy1, aBusy2, aAnyBusy};
            checks++;
            if (obs !== got) begin
                failures++;
                $display("FAIL scoreboard[%0d] got=%h want=%h", i, obs, got);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got;
        logic [69:0] obs;
        s.push_back(mkS(0, 0, 0, 0, 1, 1, 1, 2));
        e.push_back(mkE(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mkS(0, 0, 0, 0, 1, 2, 1, 2));
        e.push_back(mkE(0, 0, 1, 0, 1, 0, 0, 1, 0, 1));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 1, 2));
        e.push_back(mkE(0, 0, 1, 1, 1, 0, 0, 1, 1, 1));
        s.push_back(mkS(0, 1, 1, 'h1111, 0, 0, 1, 2));
        e.push_back(mkE('h1111, 0, 0, 1, 1, 0, 0, 1, 1, 1));
        s.push_back(mkS(0, 1, 2, 'h2222, 0, 0, 1, 2));
        e.push_back(mkE('h1111, 'h2222, 0, 0, 1, 'h1111, 0, 0, 1, 1));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 1, 2));
        e.push_back(mkE('h1111, 'h2222, 0, 0, 0, 'h1111, 'h2222, 0, 0, 0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i]);
            sbq.push_back(e[i]);
            @(negedge clk);
            got = sbq.pop_front();
            obs = {SrcData1, SrcData2, Busy1, Busy2, AnyBusy,
                   aSrcData1, aSrcData2, aBusy1, aBusy2, aAnyBusy};
            checks++;
            if (obs !== got) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%h want=%h", i, obs, got);
            end
        end
    endtask

    task automatic test_issue_write_reset();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got;
        logic [69:0] obs;
        s.push_back(mkS(0, 1, 9, 'h0009, 1, 9, 9, 9));
        e.push_back(mkE('h0009, 'h0009, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 9, 9));
        e.push_back(mkE('h0009, 'h0009, 1, 1, 1, 'h0009, 'h0009, 1, 1, 1));
        s.push_back(mkS(1, 1, 9, 'h5555, 0, 0, 9, 9));
        e.push_back(mkE('h0009, 'h0009, 1, 1, 1, 'h0009, 'h0009, 1, 1, 1));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 9, 5));
        e.push_back(mkE(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mkS(0, 0, 0, 0, 0, 0, 3, 7));
        e.push_back(mkE(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i]);
            sbq.push_back(e[i]);
            @(negedge clk);
            got = sbq.pop_front();
            obs = {SrcData1, SrcData2, Busy1, Busy2, AnyBusy,
                   aSrcData1, aSrcData2, aBusy1, aBusy2, aAnyBusy};
            checks++;
            if (obs !== got) begin
                failures++;
                $display("FAIL issue_write_reset[%0d] got=%h want=%h", i, obs, got);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_back_to_back();
        test_issue_write_reset();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d want=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
